// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg - elastic pipeline stage register with valid/ready handshake
// on both sides, synchronous flush and a saturating stall-cycle counter.
//
// Build option: define PIPE_STAGE_SKID_EN to add a second (skid) entry and
// make in_ready a register output. With the macro undefined the stage holds
// at most one entry and in_ready is combinational from out_ready.
//
// States:
//   state | meaning
//   EMPTY | main_v=0, nothing held
//   ONE   | main_v=1, skid_v=0, main entry presented downstream
//   TWO   | main_v=1, skid_v=1, skid entry queued behind main (skid build only)
//
// Ports:
//   clk, reset_n        clock (rising edge), async active-low reset
//   in_valid/in_ready   upstream handshake, in_data payload
//   out_valid/out_ready downstream handshake, out_data payload
//   flush               synchronous kill of all held entries
//   occupancy           number of held entries
//   stall_cycles        saturating count of out_valid && !out_ready cycles
//   stall_clr           synchronous clear of stall_cycles
module pipe_stage_reg #(
  parameter int                 WIDTH       = 64,
  parameter logic [WIDTH-1:0]   RESET_DATA  = {WIDTH{1'b0}},
  parameter int                 STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   flush,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  input  logic                   stall_clr
);

  logic             main_v;
  logic [WIDTH-1:0] main_d;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = main_v && out_ready;
  assign out_valid = main_v;
  assign out_data  = main_d;

`ifdef PIPE_STAGE_SKID_EN
  logic             skid_v;
  logic [WIDTH-1:0] skid_d;

  // skid_v is a flop, so flush is the only combinational term on in_ready.
  assign in_ready  = !skid_v && !flush;
  assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!main_v) begin
      main_v <= in_xfer;
    end else if (!skid_v) begin
      if (out_xfer && !in_xfer)
        main_v <= 1'b0;
      else if (in_xfer && !out_xfer)
        skid_v <= 1'b1;
    end else if (out_xfer) begin
      skid_v <= 1'b0;
    end
  end

  // Payload moves are gated only by transfers; flush leaves data untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_d <= RESET_DATA;
      skid_d <= RESET_DATA;
    end else if (!main_v) begin
      if (in_xfer)
        main_d <= in_data;
    end else if (!skid_v) begin
      if (in_xfer && out_xfer)
        main_d <= in_data;
      else if (in_xfer)
        skid_d <= in_data;
    end else if (out_xfer) begin
      main_d <= skid_d;
    end
  end
`else
  // Single entry: a new payload can only land when the slot is free or
  // being emptied in the same cycle.
  assign in_ready  = (!main_v || out_ready) && !flush;
  assign occupancy = {1'b0, main_v};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      main_v <= 1'b0;
    else if (flush)
      main_v <= 1'b0;
    else if (in_xfer)
      main_v <= 1'b1;
    else if (out_xfer)
      main_v <= 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      main_d <= RESET_DATA;
    else if (in_xfer)
      main_d <= in_data;
  end
`endif

  // Clear wins over increment; flush deliberately does not touch the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stall_cycles <= '0;
    else if (stall_clr)
      stall_cycles <= '0;
    else if (main_v && !out_ready && (stall_cycles != {STALL_CNT_W{1'b1}}))
      stall_cycles <= stall_cycles + 1'b1;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  localparam int W    = 16;
  localparam int SW   = 4;
  localparam int MAXS = (1 << SW) - 1;
  localparam logic [W-1:0] RD = 16'hA5C3;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          flush = 1'b0;
  logic [1:0]    occupancy;
  logic [SW-1:0] stall_cycles;
  logic          stall_clr = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: FIFO contents plus an integer stall count.
  logic [W-1:0] q[$];
  int           stall_m = 0;
  bit           last_in_x = 1'b0;

  logic [W-1:0] items [3] = '{16'h00A1, 16'h00B2, 16'h00C3};
  logic [W-1:0] got[$];

  pipe_stage_reg #(.WIDTH(W), .RESET_DATA(RD), .STALL_CNT_W(SW)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .occupancy(occupancy),
    .stall_cycles(stall_cycles), .stall_clr(stall_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: checks DUT against the model, then advances the model
  // with the transfers that the coming rising edge will perform.
  always @(negedge clk) begin
    int n;
    bit exp_rdy, ix, ox;
    if (!reset_n) begin
      q.delete();
      stall_m   = 0;
      last_in_x = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_occupancy", 32'(occupancy), 32'(0));
      chk("rst_stall",     32'(stall_cycles), 32'(0));
      chk("rst_out_data",  32'(out_data), 32'(RD));
      chk("rst_in_ready",  32'(in_ready), 32'(!flush));
    end else begin
      n = q.size();
      if (CAP == 2) exp_rdy = !flush && (n < 2);
      else          exp_rdy = !flush && (n == 0 || out_ready);
      chk("in_ready",  32'(in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(n > 0));
      chk("occupancy", 32'(occupancy), 32'(n));
      chk("stall",     32'(stall_cycles), 32'(stall_m));
      if (n > 0) chk("out_data", 32'(out_data), 32'(q[0]));
      ox = (n > 0) && out_ready;
      ix = in_valid && exp_rdy;
      if (ox) void'(q.pop_front());
      if (ix) q.push_back(in_data);
      if (flush) q.delete();
      if (stall_clr) stall_m = 0;
      else if (n > 0 && !out_ready && stall_m < MAXS) stall_m++;
      last_in_x = ix;
    end
  end

  task automatic drive(input bit iv, input logic [W-1:0] d, input bit ordy,
                       input bit fl, input bit clr);
    @(posedge clk); #1;
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl; stall_clr = clr;
  endtask

  // Offer n_items consecutive payloads with downstream stalled.
  task automatic fill(input int n_items, input logic [W-1:0] base);
    int k;
    k = 0;
    drive(1'b1, base, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (last_in_x) k++;
      in_valid = (k < n_items);
      in_data  = base + W'(k);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int idx, first, last;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'(1));
    chk("reset_out_data", 32'(out_data), 32'(RD));
    #2 reset_n = 1'b1;

    // Streaming 1..8
    for (int k = 1; k <= 9; k++) begin
      drive(k <= 8, W'(k), 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      if (k == 1) chk("stream_first_empty", 32'(out_valid), 32'(0));
      else begin
        chk("stream_data", 32'(out_data), 32'(k - 1));
        chk("stream_occ",  32'(occupancy), 32'(1));
      end
    end
    chk("stream_stall", 32'(stall_cycles), 32'(0));

    // Backpressure: A, B, C offered with downstream stalled
    idx = 0;
    drive(1'b1, items[0], 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (last_in_x) idx++;
      in_valid = (idx < 3);
      in_data  = items[(idx < 3) ? idx : 0];
    end
    @(negedge clk);
    chk("bp_stall3",   32'(stall_cycles), 32'(3));
    chk("bp_occ",      32'(occupancy), 32'(CAP));
    chk("bp_in_ready", 32'(in_ready), 32'(0));
    chk("bp_head",     32'(out_data), 32'(items[0]));
    @(posedge clk); #1;
    if (last_in_x) idx++;
    out_ready = 1'b1;
    in_valid  = (idx < 3);
    in_data   = items[(idx < 3) ? idx : 0];
    got.delete();
    first = -1; last = -1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        if (first < 0) first = c;
        last = c;
      end
      @(posedge clk); #1;
      if (last_in_x) idx++;
      in_valid = (idx < 3);
      in_data  = items[(idx < 3) ? idx : 0];
    end
    chk("bp_count", 32'(got.size()), 32'(3));
    for (int i = 0; i < got.size() && i < 3; i++)
      chk("bp_order", 32'(got[i]), 32'(items[i]));
    chk("bp_no_bubble", 32'(last - first), 32'(2));
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Flush while full
    fill(CAP, 16'h0D00);
    @(negedge clk);
    chk("fl_full_occ", 32'(occupancy), 32'(CAP));
    drive(1'b1, 16'h00D4, 1'b0, 1'b1, 1'b0);
    #1 chk("fl_in_ready", 32'(in_ready), 32'(0));
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("fl_out_valid", 32'(out_valid), 32'(0));
    chk("fl_occ",       32'(occupancy), 32'(0));
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("fl_d_valid", 32'(out_valid), 32'(1));
    chk("fl_d_data",  32'(out_data), 32'(16'h00D4));
    chk("fl_d_occ",   32'(occupancy), 32'(1));
    @(negedge clk);
    chk("fl_d_alone", 32'(out_valid), 32'(0));

    // Flush together with an output transfer
    fill(1, 16'h0E00);
    drive(1'b1, 16'h0EEE, 1'b1, 1'b1, 1'b0);
    #1;
    chk("flo_in_ready",  32'(in_ready), 32'(0));
    chk("flo_out_valid", 32'(out_valid), 32'(1));
    chk("flo_out_data",  32'(out_data), 32'(16'h0E00));
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("flo_empty", 32'(out_valid), 32'(0));
    chk("flo_occ",   32'(occupancy), 32'(0));

    // Asynchronous reset while full and stalling
    fill(CAP, 16'h0F00);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'(0));
    chk("ar_occ",       32'(occupancy), 32'(0));
    chk("ar_stall",     32'(stall_cycles), 32'(0));
    chk("ar_out_data",  32'(out_data), 32'(RD));
    chk("ar_in_ready",  32'(in_ready), 32'(1));
    @(negedge clk); #2;
    reset_n = 1'b1;

    // Saturation of the 4-bit stall counter, then clear during a stall
    fill(1, 16'h0123);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("sat_15", 32'(stall_cycles), 32'(15));
    @(posedge clk); #1 stall_clr = 1'b1;
    @(posedge clk); #1 stall_clr = 1'b0;
    @(negedge clk);
    chk("sat_clr", 32'(stall_cycles), 32'(0));
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic; upstream holds its payload until accepted
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if (!in_valid || last_in_x) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = W'($urandom);
      end
      out_ready = ($urandom_range(0, 99) < (((c / 500) % 2 == 1) ? 25 : 80));
      flush     = ($urandom_range(0, 19) == 0);
      stall_clr = ($urandom_range(0, 39) == 0);
    end
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
